// File: rtl/pipe_lfa_adder.sv
// pipe_lfa_adder: pipelined Ladner-Fischer prefix adder/subtractor with a valid/ready handshake and a sideband tag
module pipe_lfa_adder #(
  parameter int WIDTH         = 16,
  parameter int LVL_PER_STAGE = 2,
  parameter int TAG_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);
  localparam int LOG = $clog2(WIDTH);
  localparam int NS  = (LOG + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

  logic [WIDTH-1:0] b;
  logic             c0, out_rdy, ld_o, unused_p;
  logic [NS-1:0]    rdy, v_q, v_d, c0_q, c0_d, xm_q, xm_d, bm_q, bm_d;
  logic [WIDTH-1:0] g_q [NS], g_d [NS], p_q [NS], p_d [NS], bp_q [NS], bp_d [NS], gn [NS], pn [NS];
  logic [TAG_W-1:0] tag_q [NS], tag_d [NS];
  logic             ov_q, ov_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q, sum_d, sum_n;
  logic [TAG_W-1:0] otag_q, otag_d;

  assign b         = sub ? ~y : y;
  assign c0        = sub | cin;
  assign out_rdy   = !ov_q || out_ready;
  assign in_ready  = rdy[0];
  assign unused_p  = ^pn[NS-1];
  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_tag   = otag_q;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic             up_v, ld, c0_n, xm_n, bm_n;
    logic [WIDTH-1:0] g_n, p_n, bp_n;
    logic [TAG_W-1:0] tag_n;
    logic [WIDTH-1:0] gv [LVL_PER_STAGE+1], pv [LVL_PER_STAGE+1];
    if (k == 0) begin : g_first
      // carry-in folded into bit 0 generate so the prefix tree yields carries directly
      assign up_v  = in_valid;
      assign g_n   = (x & b) | {{(WIDTH-1){1'b0}}, (x[0] ^ b[0]) & c0};
      assign p_n   = x ^ b;
      assign bp_n  = x ^ b;
      assign c0_n  = c0;
      assign xm_n  = x[WIDTH-1];
      assign bm_n  = b[WIDTH-1];
      assign tag_n = in_tag;
    end else begin : g_next
      assign up_v  = v_q[k-1];
      assign g_n   = gn[k-1];
      assign p_n   = pn[k-1];
      assign bp_n  = bp_q[k-1];
      assign c0_n  = c0_q[k-1];
      assign xm_n  = xm_q[k-1];
      assign bm_n  = bm_q[k-1];
      assign tag_n = tag_q[k-1];
    end
    // a stage can take new data if it or any stage below it is empty, or the output drains
    assign rdy[k]   = !(&v_q[NS-1:k]) || out_rdy;
    assign ld       = rdy[k] && up_v;
    assign v_d[k]   = rdy[k] ? up_v : v_q[k];
    assign g_d[k]   = ld ? g_n : g_q[k];
    assign p_d[k]   = ld ? p_n : p_q[k];
    assign bp_d[k]  = ld ? bp_n : bp_q[k];
    assign c0_d[k]  = ld ? c0_n : c0_q[k];
    assign xm_d[k]  = ld ? xm_n : xm_q[k];
    assign bm_d[k]  = ld ? bm_n : bm_q[k];
    assign tag_d[k] = ld ? tag_n : tag_q[k];
    assign gv[0] = g_q[k];
    assign pv[0] = p_q[k];
    for (genvar l = 0; l < LVL_PER_STAGE; l++) begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (k * LVL_PER_STAGE + l < LOG && ((i >> (k * LVL_PER_STAGE + l)) & 1) == 1) begin : g_op
          localparam int J = ((i >> (k * LVL_PER_STAGE + l)) << (k * LVL_PER_STAGE + l)) - 1;
          assign gv[l+1][i] = gv[l][i] | (pv[l][i] & gv[l][J]);
          assign pv[l+1][i] = pv[l][i] & pv[l][J];
        end else begin : g_pass
          assign gv[l+1][i] = gv[l][i];
          assign pv[l+1][i] = pv[l][i];
        end
      end
    end
    assign gn[k] = gv[LVL_PER_STAGE];
    assign pn[k] = pv[LVL_PER_STAGE];
  end

  // last stage: sum XOR, carry-out and signed overflow ahead of the output register
  always_comb begin
    sum_n  = bp_q[NS-1] ^ {gn[NS-1][WIDTH-2:0], c0_q[NS-1]};
    ld_o   = out_rdy && v_q[NS-1];
    ov_d   = out_rdy ? v_q[NS-1] : ov_q;
    sum_d  = ld_o ? sum_n : sum_q;
    cout_d = ld_o ? gn[NS-1][WIDTH-1] : cout_q;
    ovf_d  = ld_o ? (xm_q[NS-1] == bm_q[NS-1]) && (sum_n[WIDTH-1] != xm_q[NS-1]) : ovf_q;
    otag_d = ld_o ? tag_q[NS-1] : otag_q;
  end

  // all pipeline state, cleared asynchronously so in-flight work is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c0_q   <= '0;
      xm_q   <= '0;
      bm_q   <= '0;
      g_q    <= '{default: '0};
      p_q    <= '{default: '0};
      bp_q   <= '{default: '0};
      tag_q  <= '{default: '0};
      ov_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      otag_q <= '0;
    end else begin
      v_q    <= v_d;
      c0_q   <= c0_d;
      xm_q   <= xm_d;
      bm_q   <= bm_d;
      g_q    <= g_d;
      p_q    <= p_d;
      bp_q   <= bp_d;
      tag_q  <= tag_d;
      ov_q   <= ov_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      otag_q <= otag_d;
    end
  end
endmodule

// File: tb/tb_pipe_lfa_adder.sv
// tb_pipe_lfa_adder: scoreboard bench for pipe_lfa_adder at default parameters
module tb_pipe_lfa_adder;
  localparam int W  = 16;
  localparam int TW = 4;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic          out_valid, out_ready = 1'b0, cout, ovf;
  logic [W-1:0]  x = '0, y = '0, sum;
  logic [TW-1:0] in_tag = '0, out_tag;

  typedef struct {
    logic [W+TW+1:0] res;
    int              at;
  } ent_t;

  ent_t            q[$];
  int              total = 0, bad = 0, cyc_n = 0, last_lat = 0;
  logic            dflag = 1'b0;
  logic [W+TW+1:0] dexp = '0;

  always #5 clk = ~clk;

  pipe_lfa_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .out_tag(out_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+TW+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                            input logic ca, input logic sa, input logic [TW-1:0] ta);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         o;
    bb = sa ? ~ya : ya;
    r  = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, (sa | ca)};
    o  = (xa[W-1] == bb[W-1]) && (r[W-1] != xa[W-1]);
    return {ta, o, r[W], r[W-1:0]};
  endfunction

  task automatic cyc();
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("underflow", 1, 0);
      else begin
        ent_t e;
        e = q.pop_front();
        check("res", {out_tag, ovf, cout, sum}, e.res);
        last_lat = cyc_n - e.at;
      end
    end
    if (in_valid && in_ready)
      q.push_back('{dflag ? dexp : model(x, y, cin, sub, in_tag), cyc_n});
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ca, input logic sa,
                      input logic [TW-1:0] ta, input logic [W-1:0] es, input logic ec, input logic eo);
    x = xa; y = ya; cin = ca; sub = sa; in_tag = ta;
    in_valid = 1'b1;
    dflag = 1'b1;
    dexp = {ta, eo, ec, es};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    check("rst_state", {out_valid, out_tag, ovf, cout, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check("rdy_after_rst", in_ready, 1);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h1, 16'h0000, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    check("lat", last_lat, 3);

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h2, 16'h8000, 1'b0, 1'b1);
    cyc();
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 4'h3, 16'hFFFE, 1'b0, 1'b0);
    cyc();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 4'h4, 16'h7FFF, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    repeat (5) cyc();
    check("q_empty_dir", q.size(), 0);

    dflag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = W'($urandom); y = W'($urandom); in_tag = i[3:0]; sub = i[0]; cin = i[1];
      in_valid = 1'b1;
      check("tput_rdy", in_ready, 1);
      cyc();
    end
    in_valid = 1'b0;
    repeat (5) cyc();

    out_ready = 1'b0;
    send(16'd1, 16'd1, 1'b0, 1'b0, 4'h1, 16'd2, 1'b0, 1'b0);
    cyc();
    send(16'd2, 16'd2, 1'b0, 1'b0, 4'h2, 16'd4, 1'b0, 1'b0);
    cyc();
    send(16'd3, 16'd3, 1'b0, 1'b0, 4'h3, 16'd6, 1'b0, 1'b0);
    cyc();
    dflag = 1'b0;
    x = 16'd9; y = 16'd9; in_tag = 4'h4;
    check("full_rdy", in_ready, 0);
    check("full_ov", out_valid, 1);
    check("hold0", {out_tag, sum}, {4'h1, 16'h0002});
    cyc();
    cyc();
    check("full_rdy2", in_ready, 0);
    check("hold1", {out_tag, sum}, {4'h1, 16'h0002});
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      check("drain_v", out_valid, 1);
      cyc();
    end
    check("q_empty_stall", q.size(), 0);

    send(16'h1234, 16'h1111, 1'b0, 1'b0, 4'h5, 16'h2345, 1'b0, 1'b0);
    cyc();
    send(16'h0F0F, 16'h0101, 1'b0, 1'b1, 4'h6, 16'h0E0E, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    dflag = 1'b0;
    cyc();
    check("pre_rst_v", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {out_valid, out_tag, ovf, cout, sum}, 0);
    #2;
    rst_n = 1'b1;
    q.delete();
    check("rdy_after_rst2", in_ready, 1);
    repeat (5) begin
      check("no_stale", out_valid, 0);
      cyc();
    end

    repeat (3000) begin
      in_valid = 1'($urandom_range(0, 1));
      x = W'($urandom); y = W'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_tag = TW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      cyc();
      n++;
    end
    check("drain_all", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
